// File: rtl/airlock_pkg.sv
// airlock_pkg: shared state encoding, LED codes and default timing for the
// airlock sequencer. State encodings double as the reset_leds status codes.
package airlock_pkg;

   localparam logic [3:0] LED_FAULT = 4'hF;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'h0,
      ST_WAIT  = 4'h1,
      ST_FILL  = 4'h2,
      ST_FULL  = 4'h3,
      ST_DRAIN = 4'h4,
      ST_FAULT = LED_FAULT
   } state_t;

   // 1 s at 50 MHz
   localparam int unsigned TIMEOUT_DEFAULT = 50_000_000;

   // Bit positions of the processor event lines in the edge-detect vector
   localparam int unsigned EV_W         = 9;
   localparam int unsigned EV_BATH_ARR  = 0;
   localparam int unsigned EV_BATH_LV   = 1;
   localparam int unsigned EV_PERSON    = 2;
   localparam int unsigned EV_PRESSURE  = 3;
   localparam int unsigned EV_INNER_SW  = 4;
   localparam int unsigned EV_OUTER_SW  = 5;
   localparam int unsigned EV_WAIT_FIN  = 6;
   localparam int unsigned EV_FILL_FIN  = 7;
   localparam int unsigned EV_DRAIN_FIN = 8;

endpackage

// File: rtl/airlock_sequencer_edge_detect.sv
// edge_detect: registered rising-edge detector for a vector of level inputs.
// While reset is held the previous-value copy tracks the inputs, so a line
// that is already high when reset releases never produces an edge.
module edge_detect
   import airlock_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sig,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] prev;

   // Capture previous input value and register the rising-edge pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= sig;
         rise <= '0;
      end else begin
         prev <= sig;
         rise <= sig & ~prev;
      end
   end

endmodule

// File: rtl/airlock_sequencer.sv
// airlock_sequencer: airlock chamber controller with hardware door/pump
// interlocks, driven by the processor's PIO event lines.
// Optional watchdog: define AIRLOCK_WATCHDOG_EN to fault WAIT/FILL/DRAIN
// after TIMEOUT_CYCLES clocks without an exit edge.
module airlock_sequencer
   import airlock_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       bath_arriving,
   input  logic       bath_leaving,
   input  logic       person_check,
   input  logic       pressure_check,
   input  logic       inner_door_sw,
   input  logic       outer_door_sw,
   input  logic       wait_finished,
   input  logic       fill_finished,
   input  logic       drain_finished,
   output logic       filling,
   output logic       draining,
   output logic       waiting,
   output logic       inner_door,
   output logic       outer_door,
   output logic [3:0] reset_leds
);

   logic [EV_W-1:0] ev_in;
   logic [EV_W-1:0] rise;

   state_t state;
   state_t state_next;
   logic   inner_q;
   logic   inner_next;
   logic   outer_q;
   logic   outer_next;

   assign ev_in[EV_BATH_ARR]  = bath_arriving;
   assign ev_in[EV_BATH_LV]   = bath_leaving;
   assign ev_in[EV_PERSON]    = person_check;
   assign ev_in[EV_PRESSURE]  = pressure_check;
   assign ev_in[EV_INNER_SW]  = inner_door_sw;
   assign ev_in[EV_OUTER_SW]  = outer_door_sw;
   assign ev_in[EV_WAIT_FIN]  = wait_finished;
   assign ev_in[EV_FILL_FIN]  = fill_finished;
   assign ev_in[EV_DRAIN_FIN] = drain_finished;

   edge_detect #(.WIDTH(EV_W)) u_edge (
      .clk   (clk),
      .reset (reset),
      .sig   (ev_in),
      .rise  (rise)
   );

`ifdef AIRLOCK_WATCHDOG_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] wd_cnt;
   logic [CNT_W-1:0] wd_next;
   logic             timed;
   logic             wd_expired;

   assign timed      = (state == ST_WAIT) || (state == ST_FILL) || (state == ST_DRAIN);
   assign wd_expired = timed && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Watchdog counter: restarts on each state change, runs in timed states
   always_comb begin
      wd_next = wd_cnt;
      if (state_next != state) begin
         wd_next = '0;
      end else if (timed) begin
         wd_next = wd_cnt + 1'b1;
      end
   end
`endif

   // State, door and watchdog registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         inner_q <= 1'b0;
         outer_q <= 1'b0;
`ifdef AIRLOCK_WATCHDOG_EN
         wd_cnt  <= '0;
`endif
      end else begin
         state   <= state_next;
         inner_q <= inner_next;
         outer_q <= outer_next;
`ifdef AIRLOCK_WATCHDOG_EN
         wd_cnt  <= wd_next;
`endif
      end
   end

   // Next state and door toggles; a door-switch edge pre-empts any
   // transition requested in the same cycle
   always_comb begin
      state_next = state;
      inner_next = inner_q;
      outer_next = outer_q;
      case (state)
         ST_IDLE: begin
            if (rise[EV_INNER_SW]) begin
               inner_next = ~inner_q;
            end else if (rise[EV_BATH_ARR] && !inner_q) begin
               state_next = ST_WAIT;
            end else if (rise[EV_BATH_LV] && !inner_q && person_check) begin
               state_next = ST_FILL;
            end
         end
         ST_WAIT: begin
            if (rise[EV_WAIT_FIN]) state_next = ST_FILL;
         end
         ST_FILL: begin
            if (rise[EV_FILL_FIN]) state_next = ST_FULL;
         end
         ST_FULL: begin
            if (rise[EV_OUTER_SW]) begin
               outer_next = ~outer_q;
            end else if (rise[EV_PRESSURE] && !outer_q) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (rise[EV_DRAIN_FIN]) state_next = ST_IDLE;
         end
         ST_FAULT: begin
            state_next = ST_FAULT;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
`ifdef AIRLOCK_WATCHDOG_EN
      if (wd_expired) state_next = ST_FAULT;
`endif
      // Doors can only be open in their owning state
      if (state_next != ST_IDLE) inner_next = 1'b0;
      if (state_next != ST_FULL) outer_next = 1'b0;
   end

   // Moore output decode from the registered state and door flags
   always_comb begin
      waiting    = (state == ST_WAIT);
      filling    = (state == ST_FILL);
      draining   = (state == ST_DRAIN);
      inner_door = inner_q && (state == ST_IDLE);
      outer_door = outer_q && (state == ST_FULL);
      reset_leds = (state == ST_FAULT) ? LED_FAULT : 4'(state);
   end

endmodule

// File: tb/tb_airlock_sequencer.sv
// tb_airlock_sequencer: directed test-plan sequences followed by randomized
// input toggling, every cycle checked against a behavioural airlock model.
module tb_airlock_sequencer;

   localparam int unsigned T = 16;

   localparam int B_ARR    = 0;
   localparam int B_LEAVE  = 1;
   localparam int B_PERSON = 2;
   localparam int B_PRESS  = 3;
   localparam int B_INNER  = 4;
   localparam int B_OUTER  = 5;
   localparam int B_WAITF  = 6;
   localparam int B_FILLF  = 7;
   localparam int B_DRAINF = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] iv;
   logic       filling, draining, waiting, inner_door, outer_door;
   logic [3:0] reset_leds;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // model: status code, door flags, pending edges, previous inputs, dwell
   int         m_led;
   bit         m_in, m_out;
   logic [8:0] m_pend, m_prev;
   int         m_dwell;

   always #5 clk = ~clk;

   airlock_sequencer #(.TIMEOUT_CYCLES(T)) dut (
      .clk            (clk),
      .reset          (reset),
      .bath_arriving  (iv[B_ARR]),
      .bath_leaving   (iv[B_LEAVE]),
      .person_check   (iv[B_PERSON]),
      .pressure_check (iv[B_PRESS]),
      .inner_door_sw  (iv[B_INNER]),
      .outer_door_sw  (iv[B_OUTER]),
      .wait_finished  (iv[B_WAITF]),
      .fill_finished  (iv[B_FILLF]),
      .drain_finished (iv[B_DRAINF]),
      .filling        (filling),
      .draining       (draining),
      .waiting        (waiting),
      .inner_door     (inner_door),
      .outer_door     (outer_door),
      .reset_leds     (reset_leds)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the airlock rules; edges seen at one edge act at the next
   task automatic model_edge();
      int old;
      bit timed;
      if (reset) begin
         m_led = 0; m_in = 0; m_out = 0; m_dwell = 0;
         m_pend = '0; m_prev = iv;
         return;
      end
      old = m_led;
      case (m_led)
         0: begin
            if (m_pend[B_INNER]) m_in = !m_in;
            else if (m_pend[B_ARR] && !m_in) m_led = 1;
            else if (m_pend[B_LEAVE] && !m_in && iv[B_PERSON]) m_led = 2;
         end
         1: if (m_pend[B_WAITF]) m_led = 2;
         2: if (m_pend[B_FILLF]) m_led = 3;
         3: begin
            if (m_pend[B_OUTER]) m_out = !m_out;
            else if (m_pend[B_PRESS] && !m_out) m_led = 4;
         end
         4: if (m_pend[B_DRAINF]) m_led = 0;
         default: ;
      endcase
      timed = (old == 1) || (old == 2) || (old == 4);
`ifdef AIRLOCK_WATCHDOG_EN
      if (timed && m_dwell == int'(T) - 1) m_led = 15;
`endif
      if (m_led != old) m_dwell = 0;
      else if (timed) m_dwell++;
      if (m_led != 0) m_in = 0;
      if (m_led != 3) m_out = 0;
      m_pend = iv & ~m_prev;
      m_prev = iv;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check("outs", {filling, draining, waiting, inner_door, outer_door, reset_leds},
            {m_led == 2, m_led == 4, m_led == 1, m_in && m_led == 0, m_out && m_led == 3, 4'(m_led)});
   endtask

   task automatic hold(input int n);
      repeat (n) step();
   endtask

   // Rising edge on one line, then wait for the FSM to act on it
   task automatic pulse(input int idx);
      iv[idx] = 1'b1;
      step();
      iv[idx] = 1'b0;
      step();
   endtask

   initial begin
      iv    = '0;
      reset = 1'b1;
      step();
      check("reset_leds", reset_leds, 4'h0);
      check("reset_outs", {filling, draining, waiting, inner_door, outer_door}, 5'b0);
      reset = 1'b0;
      step();

      // arrival sequence
      pulse(B_ARR);
      check("arr_leds", reset_leds, 4'h1);
      check("arr_waiting", waiting, 1'b1);
      pulse(B_WAITF);
      check("fill_leds", reset_leds, 4'h2);
      check("fill_flags", {waiting, filling}, 2'b01);
      pulse(B_FILLF);
      check("full_leds", reset_leds, 4'h3);
      check("full_filling", filling, 1'b0);

      // outer door gating in FULL
      pulse(B_OUTER);
      check("outer_open", outer_door, 1'b1);
      pulse(B_PRESS);
      check("press_ignored", reset_leds, 4'h3);
      pulse(B_OUTER);
      check("outer_closed", outer_door, 1'b0);
      pulse(B_PRESS);
      check("drain_leds", reset_leds, 4'h4);
      check("drain_flag", draining, 1'b1);
      pulse(B_DRAINF);
      check("idle_leds", reset_leds, 4'h0);

      // interlocks in IDLE
      pulse(B_INNER);
      check("inner_open", inner_door, 1'b1);
      pulse(B_ARR);
      check("arr_blocked", reset_leds, 4'h0);
      pulse(B_INNER);
      check("inner_closed", inner_door, 1'b0);
      pulse(B_OUTER);
      check("outer_idle", {outer_door, reset_leds}, 5'h0);

      // departure gating on person presence
      iv[B_PERSON] = 1'b0;
      pulse(B_LEAVE);
      check("leave_empty", reset_leds, 4'h0);
      iv[B_PERSON] = 1'b1;
      pulse(B_LEAVE);
      check("leave_person", reset_leds, 4'h2);
      iv[B_PERSON] = 1'b0;

      // simultaneous door switch and pressure request in FULL
      pulse(B_FILLF);
      iv[B_OUTER] = 1'b1;
      iv[B_PRESS] = 1'b1;
      step();
      iv[B_OUTER] = 1'b0;
      iv[B_PRESS] = 1'b0;
      step();
      check("simul_door", {outer_door, reset_leds}, {1'b1, 4'h3});
      hold(2);
      check("simul_nodrain", reset_leds, 4'h3);
      pulse(B_OUTER);
      pulse(B_PRESS);
      check("drain_again", reset_leds, 4'h4);

      // reset in the middle of DRAIN
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_reset", {filling, draining, waiting, inner_door, outer_door, reset_leds}, 9'h0);

      // line held high across reset release is not an edge
      iv[B_ARR] = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      hold(3);
      check("held_no_edge", reset_leds, 4'h0);
      iv[B_ARR] = 1'b0;
      step();

`ifdef AIRLOCK_WATCHDOG_EN
      pulse(B_ARR);
      pulse(B_WAITF);
      hold(int'(T) - 1);
      check("wd_before", reset_leds, 4'h2);
      step();
      check("wd_fault", reset_leds, 4'hF);
      check("wd_filling", filling, 1'b0);
      pulse(B_FILLF);
      pulse(B_INNER);
      check("fault_sticky", {inner_door, reset_leds}, {1'b0, 4'hF});
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("fault_reset", reset_leds, 4'h0);
`endif

      // randomized toggling of every line with occasional resets
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 149) == 0);
         for (int b = 0; b < 9; b++) begin
            if ($urandom_range(0, 5) == 0) iv[b] = ~iv[b];
         end
         step();
      end
      reset = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
